// File: rtl/mips_exe_pkg.sv
// Shared EXE_CMD opcodes and multiplier FSM states for the execute stage.
package mips_exe_pkg;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_SLT = 4'b1011;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: stall for 1+32/RADIX_BITS cycles, product valid for one DONE cycle.
// Operands are latched at start, so input changes while busy do not disturb the result.
module mul_iter
  import mips_exe_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        done,
  output logic [31:0] prod
);

  localparam int ITER  = 32 / RADIX_BITS;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  mul_state_t         state, state_nxt;
  logic [31:0]        mcand, mplier, acc, partial;
  logic [CNT_W-1:0]   cnt;
  logic               busy_c;

  // Partial product of the multiplicand with the low RADIX_BITS multiplier bits.
  always_comb begin
    partial = '0;
    for (int i = 0; i < RADIX_BITS; i++) begin
      if (mplier[i]) partial = partial + (mcand << i);
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          busy_c    = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy_c = 1'b1;
        if (cnt == '0) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A held MUL opcode must not raise the stall while reset is asserted.
  assign stall = busy_c & ~rst;
  assign prod  = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(ITER - 1);
          end
        end
        ST_BUSY: begin
          acc    <= acc + partial;
          mcand  <= mcand << RADIX_BITS;
          mplier <= mplier >> RADIX_BITS;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage: combinational ALU and branch adder, MUL stalls upstream for 1+32/RADIX_BITS cycles.
// exe_stall holds PC, IF/ID and ID/EXE; EXE/MEM captures the product on the DONE cycle.
module exe_stage_mc
  import mips_exe_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  EXE_CMD,
  input  logic [31:0] Val1,
  input  logic [31:0] Val2,
  input  logic [31:0] PC_in,
  output logic [31:0] ALU_result,
  output logic [31:0] Br_addr,
  output logic        exe_stall
);

  logic [4:0]         shamt;
  logic signed [31:0] sra_res;
  logic [31:0]        mul_prod;
  logic               mul_done;

  assign shamt   = Val2[4:0];
  assign sra_res = $signed(Val1) >>> shamt;
  assign Br_addr = PC_in + {Val2[29:0], 2'b00};

  mul_iter #(.RADIX_BITS(RADIX_BITS)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (EXE_CMD == CMD_MUL),
    .a     (Val1),
    .b     (Val2),
    .stall (exe_stall),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    ALU_result = '0;
    case (EXE_CMD)
      CMD_ADD: ALU_result = Val1 + Val2;
      CMD_SUB: ALU_result = Val1 - Val2;
      CMD_AND: ALU_result = Val1 & Val2;
      CMD_OR:  ALU_result = Val1 | Val2;
      CMD_NOR: ALU_result = ~(Val1 | Val2);
      CMD_XOR: ALU_result = Val1 ^ Val2;
      CMD_SLL: ALU_result = Val1 << shamt;
      CMD_SRA: ALU_result = sra_res;
      CMD_SRL: ALU_result = Val1 >> shamt;
      CMD_SLT: ALU_result = {31'b0, sra_res_lt(Val1, Val2)};
      CMD_MUL: ALU_result = mul_done ? mul_prod : '0;
      default: ALU_result = '0;
    endcase
  end

  function automatic logic sra_res_lt(input logic [31:0] x, input logic [31:0] y);
    return $signed(x) < $signed(y);
  endfunction

endmodule

// File: tb/tb_exe_stage_mc.sv
module tb_exe_stage_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cmd1, cmd4;
  logic [31:0] a1, b1, a4, b4, pc;
  logic [31:0] res1, res4, br1, br4;
  logic        stall1, stall4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exe_stage_mc #(.RADIX_BITS(1)) dut (
    .clk(clk), .rst(rst), .EXE_CMD(cmd1), .Val1(a1), .Val2(b1), .PC_in(pc),
    .ALU_result(res1), .Br_addr(br1), .exe_stall(stall1)
  );

  exe_stage_mc #(.RADIX_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .EXE_CMD(cmd4), .Val1(a4), .Val2(b4), .PC_in(pc),
    .ALU_result(res4), .Br_addr(br4), .exe_stall(stall4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the opcode table using plain arithmetic.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] x,
                                          input logic [31:0] y);
    int unsigned sh;
    logic [63:0] p;
    sh = y % 32;
    case (c)
      4'd0:  return x + y;
      4'd2:  return x - y;
      4'd4:  return x & y;
      4'd5:  return x | y;
      4'd6:  return ~(x | y);
      4'd7:  return x ^ y;
      4'd8:  return x << sh;
      4'd9:  return (x >> sh) | (x[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd10: return x >> sh;
      4'd11: return ((x ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd12: begin p = {32'h0, x} * {32'h0, y}; return p[31:0]; end
      default: return 32'h0;
    endcase
  endfunction

  // Single-cycle op on the radix-1 DUT; called just after a rising edge.
  task automatic alu_op(input string tag, input logic [3:0] c, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] p);
    cmd1 = c; a1 = x; b1 = y; pc = p;
    @(negedge clk);
    chk({tag, "_res"}, {32'h0, res1}, {32'h0, ref_alu(c, x, y)});
    chk({tag, "_br"}, {32'h0, br1}, {32'h0, p + y * 32'd4});
    chk({tag, "_stall"}, {63'h0, stall1}, 64'h0);
    @(posedge clk); #1;
  endtask

  // MUL on the chosen DUT; measures the stall window and checks the DONE-cycle result.
  task automatic do_mul(input string tag, input bit sel4, input logic [31:0] x,
                        input logic [31:0] y);
    int n;
    int exp_n;
    bit first;
    bit stl;
    logic [31:0] r;
    exp_n = sel4 ? 1 + 32 / 4 : 1 + 32;
    if (sel4) begin cmd4 = 4'hC; a4 = x; b4 = y; end
    else      begin cmd1 = 4'hC; a1 = x; b1 = y; end
    n = 0;
    first = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      stl = sel4 ? stall4 : stall1;
      if (k == 0) first = stl;
      if (!stl) break;
      n++;
      @(posedge clk); #1;
    end
    r = sel4 ? res4 : res1;
    chk({tag, "_stall_first"}, {63'h0, first}, 64'h1);
    chk({tag, "_stall_len"}, 64'(n), 64'(exp_n));
    chk({tag, "_prod"}, {32'h0, r}, {32'h0, ref_alu(4'hC, x, y)});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    cmd1 = 4'h0; a1 = 32'd3; b1 = 32'd4; pc = 32'h0;
    cmd4 = 4'h0; a4 = 32'h0; b4 = 32'h0;
    #2;
    chk("rst_stall", {63'h0, stall1}, 64'h0);
    chk("rst_add_comb", {32'h0, res1}, 64'd7);
    cmd1 = 4'hC;
    #1;
    chk("rst_mul_no_stall", {63'h0, stall1}, 64'h0);
    cmd1 = 4'h0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    alu_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h0);
    alu_op("sub_neg", 4'd2, 32'h0, 32'h1, 32'h100);
    alu_op("sra_neg", 4'd9, 32'h8000_0000, 32'd4, 32'h0);
    alu_op("slt_m1_1", 4'd11, 32'hFFFF_FFFF, 32'd1, 32'h0);
    alu_op("slt_1_m1", 4'd11, 32'd1, 32'hFFFF_FFFF, 32'h0);
    alu_op("sll_33", 4'd8, 32'h1234_5678, 32'd33, 32'h0);
    alu_op("bad_cmd", 4'd3, 32'hDEAD_BEEF, 32'h1, 32'h0);
    alu_op("br_back", 4'd0, 32'h0, 32'hFFFF_FFFF, 32'h0040_0004);
    chk("br_const", {32'h0, br1}, {32'h0, 32'h0040_0000});

    for (int i = 0; i < 40; i++) begin
      logic [3:0] c;
      c = 4'($urandom_range(0, 15));
      if (c == 4'hC) c = 4'hF;
      alu_op("rand_alu", c, $urandom, (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             $urandom);
    end

    cmd1 = 4'h0;
    do_mul("mul_6x7", 1'b0, 32'd6, 32'd7);
    cmd1 = 4'h0;
    @(negedge clk);
    chk("mul_then_idle", {63'h0, stall1}, 64'h0);
    @(posedge clk); #1;

    do_mul("mul_ff_r1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cmd1 = 4'h0;
    do_mul("mul_ff_r4", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cmd4 = 4'h0;

    do_mul("b2b_3x5", 1'b0, 32'd3, 32'd5);
    do_mul("b2b_9x9", 1'b0, 32'd9, 32'd9);
    cmd1 = 4'h0;

    // Operand and opcode changes during BUSY must not affect the in-flight product.
    cmd1 = 4'hC; a1 = 32'd11; b1 = 32'd13;
    @(posedge clk); #1;
    cmd1 = 4'h0; a1 = 32'd99; b1 = 32'd99;
    repeat (32) @(posedge clk);
    #1;
    cmd1 = 4'hC;
    @(negedge clk);
    chk("flush_done_stall", {63'h0, stall1}, 64'h0);
    chk("flush_done_prod", {32'h0, res1}, 64'd143);
    @(posedge clk); #1;
    cmd1 = 4'h0;

    for (int i = 0; i < 3; i++) begin
      do_mul("rand_mul_r1", 1'b0, $urandom, $urandom);
      cmd1 = 4'h0;
      do_mul("rand_mul_r4", 1'b1, $urandom, $urandom);
      cmd4 = 4'h0;
    end

    // Reset mid-BUSY.
    cmd1 = 4'hC; a1 = 32'd7; b1 = 32'd7;
    repeat (11) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_stall", {63'h0, stall1}, 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy_stall", {63'h0, stall1}, 64'h0);
    chk("rst_busy_res", {32'h0, res1}, 64'h0);
    @(posedge clk); #1;
    cmd1 = 4'h0;
    rst = 1'b0;
    @(posedge clk); #1;
    do_mul("mul_2x2_post_rst", 1'b0, 32'd2, 32'd2);
    cmd1 = 4'h0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
